// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA raster / compositing slice.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - RGB222 pixel type, channel width and slice positions, BLACK constant.
//   - Output pipeline stage struct and its reset value.
//   - blend_rgb(): per-channel average used by the optional overlay blend.
// ---------------------------------------------------------------------------
package vga_pkg;

    // 640x480@60 horizontal timing (pixels)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // 640x480@60 vertical timing (lines)
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Raster counters are always this wide on the x/y ports
    localparam int CNT_W = 10;

    // RGB222 packing: {R1R0, G1G0, B1B0}
    localparam int CH_W   = 2;
    localparam int NUM_CH = 3;
    localparam int RGB_W  = CH_W * NUM_CH;
    localparam int R_LSB  = 2 * CH_W;
    localparam int G_LSB  = CH_W;
    localparam int B_LSB  = 0;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t BLACK = '0;

    // One slot of the output delay line; syncs are carried active-low
    typedef struct packed {
        rgb_t rgb;
        logic hs_n;
        logic vs_n;
    } pix_stage_t;

    localparam pix_stage_t STAGE_RESET = '{rgb: BLACK, hs_n: 1'b1, vs_n: 1'b1};

    // Per-channel (a + b) >> 1, summed one bit wider so the carry survives
    // before the shift drops the LSB.
    function automatic rgb_t blend_rgb(input rgb_t ov, input rgb_t bg);
        rgb_t            res;
        logic [CH_W:0]   sum;
        res = BLACK;
        for (int c = 0; c < NUM_CH; c++) begin
            sum = {1'b0, ov[c*CH_W +: CH_W]} + {1'b0, bg[c*CH_W +: CH_W]};
            res[c*CH_W +: CH_W] = sum[CH_W:1];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
//   Horizontal/vertical raster counters with stage-0 timing decode.
//   Ports:
//     clk, rst       pixel clock, asynchronous active-high reset
//     x, y           current h / v count (direct from the registers)
//     frame_active   high inside the visible window (combinational)
//     hs_n, vs_n     unregistered active-low syncs for the current x/y
//     frame_tick     registered one-cycle pulse when (0,0) first appears
//     frame_count    frames since reset, wraps at 256
// ---------------------------------------------------------------------------
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_active,
    output logic             hs_n,
    output logic             vs_n,
    output logic             frame_tick,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Pre-sized boundaries so every compare is width-matched
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             end_of_frame;

    assign h_wrap       = (h == H_LAST);
    assign end_of_frame = h_wrap && (v == V_LAST);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (h_wrap) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
            end else begin
                h <= h + CNT_W'(1);
            end
            // Tick lands in the cycle where (0,0) is first visible
            frame_tick <= end_of_frame;
            if (end_of_frame) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign x            = h;
    assign y            = v;
    assign frame_active = (h < H_VIS) && (v < V_VIS);
    assign hs_n         = !((h >= HS_FIRST) && (h <= HS_LAST));
    assign vs_n         = !((v >= VS_FIRST) && (v <= VS_LAST));

endmodule

// File: rtl/vga_scan_mixer.sv
// ---------------------------------------------------------------------------
// vga_scan_mixer
//   Raster generator plus overlay compositor driving registered VGA pins.
//   Ports:
//     clk, rst        pixel clock, asynchronous active-high reset
//     x, y            raster position for the overlay logic
//     frame_active    visible-window flag for the overlay logic
//     overlay_rgb     overlay colour, valid with x/y
//     overlay_active  overlay covers the pixel at x/y
//     bg_rgb          background colour, valid with x/y
//     hsync, vsync    active-low syncs, registered
//     rgb             composited RGB222, registered, black when blanked
//     frame_tick      one-cycle pulse at frame start
//     frame_count     frames since reset (8-bit, wrapping)
//   PIPE_DLY (0..3) adds identical register stages after stage 1, so
//   rgb/hsync/vsync trail x/y by 1+PIPE_DLY cycles and stay aligned.
//   Optional build macro OVERLAY_BLEND_EN: overlay pixels are averaged with
//   the background per channel instead of replacing it.
// ---------------------------------------------------------------------------
module vga_scan_mixer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_active,
    input  logic [RGB_W-1:0] overlay_rgb,
    input  logic             overlay_active,
    input  logic [RGB_W-1:0] bg_rgb,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_tick,
    output logic [7:0]       frame_count
);

    logic hs_n;
    logic vs_n;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .y            (y),
        .frame_active (frame_active),
        .hs_n         (hs_n),
        .vs_n         (vs_n),
        .frame_tick   (frame_tick),
        .frame_count  (frame_count)
    );

    // Stage 0: composite in the same cycle as x/y
    rgb_t       pix;
    pix_stage_t stage0;

    // NOTE: pix gets a default before any condition so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pix = bg_rgb;
        if (overlay_active) begin
`ifdef OVERLAY_BLEND_EN
            pix = blend_rgb(overlay_rgb, bg_rgb);
`else
            pix = overlay_rgb;
`endif
        end
        if (!frame_active) begin
            pix = BLACK;
        end
    end

    assign stage0 = '{rgb: pix, hs_n: hs_n, vs_n: vs_n};

    // Stage 1 .. 1+PIPE_DLY: rgb and syncs travel together
    pix_stage_t pipe [0:PIPE_DLY];

    // NOTE: this array is a short chain of flops, not a RAM, so it is reset
    // like any other register; blank/idle sync levels must show on the pins
    // as soon as rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                pipe[i] <= STAGE_RESET;
            end
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rgb   = pipe[PIPE_DLY].rgb;
    assign hsync = pipe[PIPE_DLY].hs_n;
    assign vsync = pipe[PIPE_DLY].vs_n;

endmodule

// File: tb/tb_vga_scan_mixer.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_mixer
//   Scoreboard bench on a scaled-down raster (25 x 10) so full frames and
//   the 256-frame counter wrap fit in a short run. Expected outputs are
//   derived from the cycle number since reset release with plain
//   arithmetic; the driver pushes them, a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_vga_scan_mixer;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int PD = 2;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FT = HT * VT;             // 250 cycles per frame

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x, y;
    logic       frame_active;
    logic [5:0] overlay_rgb = '0;
    logic       overlay_active = 1'b0;
    logic [5:0] bg_rgb = '0;
    logic       hsync, vsync;
    logic [5:0] rgb;
    logic       frame_tick;
    logic [7:0] frame_count;

    vga_scan_mixer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIPE_DLY (PD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .x              (x),
        .y              (y),
        .frame_active   (frame_active),
        .overlay_rgb    (overlay_rgb),
        .overlay_active (overlay_active),
        .bg_rgb         (bg_rgb),
        .hsync          (hsync),
        .vsync          (vsync),
        .rgb            (rgb),
        .frame_tick     (frame_tick),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] pins;    // {rgb, hsync, vsync}
    } pin_exp_t;

    typedef struct {
        int          due;
        logic [29:0] cnt;    // {x, y, frame_active, frame_tick, frame_count}
    } cnt_exp_t;

    pin_exp_t pin_q[$];
    cnt_exp_t cnt_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_drv  = 0;
    int n_mon  = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference compositing from the colour rules, channel by channel
    function automatic logic [5:0] ref_pix(input logic oa, input logic [5:0] o,
                                           input logic [5:0] b, input bit vis);
        logic [5:0] res;
        int         oc, bc;
        if (!vis) return 6'd0;
        if (!oa)  return b;
`ifdef OVERLAY_BLEND_EN
        res = '0;
        for (int c = 0; c < 3; c++) begin
            oc = (int'(o) >> (2 * c)) & 3;
            bc = (int'(b) >> (2 * c)) & 3;
            res = res | 6'(((oc + bc) / 2) << (2 * c));
        end
        return res;
`else
        res = o;
        return res;
`endif
    endfunction

    // Drive random inputs for cycle n and push what that cycle must produce
    task automatic drive_cycle(input int n);
        int         h, v, frame;
        bit         vis, hs_lo, vs_lo, tick;
        logic [5:0] pix;
        pin_exp_t   pe;
        cnt_exp_t   ce;

        if (n % 7 == 3) begin
            bg_rgb         = 6'b00_00_11;
            overlay_rgb    = 6'b11_00_00;
            overlay_active = 1'b1;
        end else begin
            bg_rgb         = 6'($urandom);
            overlay_rgb    = 6'($urandom);
            overlay_active = 1'($urandom);
        end

        h     = n % HT;
        v     = (n / HT) % VT;
        frame = n / FT;
        vis   = (h < HA) && (v < VA);
        hs_lo = (h >= HA + HF) && (h < HA + HF + HS);
        vs_lo = (v >= VA + VF) && (v < VA + VF + VS);
        tick  = (n > 0) && (n % FT == 0);
        pix   = ref_pix(overlay_active, overlay_rgb, bg_rgb, vis);

        ce.due = n;
        ce.cnt = {10'(h), 10'(v), vis, tick, 8'(frame % 256)};
        cnt_q.push_back(ce);

        pe.due  = n + 1 + PD;
        pe.pins = {pix, !hs_lo, !vs_lo};
        pin_q.push_back(pe);
    endtask

    // Release reset between edges; the pipeline still shows reset values
    // until the first composited pixel arrives 1+PD cycles later.
    task automatic release_reset();
        pin_exp_t pe;
        @(posedge clk);
        #2;
        rst = 1'b0;
        pin_q.delete();
        cnt_q.delete();
        n_drv = 0;
        n_mon = 0;
        for (int k = 0; k <= PD; k++) begin
            pe.due  = k;
            pe.pins = {6'd0, 1'b1, 1'b1};
            pin_q.push_back(pe);
        end
        drive_cycle(0);
        mon_en = 1'b1;
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            #1;
            n_drv++;
            drive_cycle(n_drv);
        end
    endtask

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge clk) begin
        pin_exp_t pe;
        cnt_exp_t ce;
        if (mon_en) begin
            while (cnt_q.size() > 0 && cnt_q[0].due <= n_mon) begin
                ce = cnt_q.pop_front();
                check($sformatf("counters@%0d", ce.due),
                      {2'b0, x, y, frame_active, frame_tick, frame_count},
                      {2'b0, ce.cnt});
            end
            while (pin_q.size() > 0 && pin_q[0].due <= n_mon) begin
                pe = pin_q.pop_front();
                check($sformatf("pins@%0d", pe.due),
                      {24'b0, rgb, hsync, vsync}, {24'b0, pe.pins});
            end
            n_mon++;
        end
    end

    initial begin
        // Reset held from time zero
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb",   32'(rgb),         32'd0);
        check("rst_syncs", {30'b0, hsync, vsync}, 32'd3);
        check("rst_xy",    {12'b0, x, y},    32'd0);
        check("rst_count", {23'b0, frame_tick, frame_count}, 32'd0);

        // Two frames plus part of a third, stopping mid-frame at x=12,y=4
        release_reset();
        run_cycles(2 * FT + 4 * HT + 12);

        // Asynchronous reset mid-frame: values change without a clock edge
        #1;
        mon_en = 1'b0;
        check("pre_rst_count", 32'(frame_count == 8'd2), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rgb",   32'(rgb),                  32'd0);
        check("async_syncs", {30'b0, hsync, vsync},     32'd3);
        check("async_xy",    {12'b0, x, y},             32'd0);
        check("async_count", {23'b0, frame_tick, frame_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("held_xy", {12'b0, x, y}, 32'd0);

        // Restart from (0,0) and run past the 255 -> 0 frame counter wrap
        release_reset();
        run_cycles(256 * FT + 3 * HT);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
